matrix_output_formatter: RTL and testbench

- Transmit-side counterpart of the matrix input path. Reads an m x n matrix from matrix storage, starting at a base address.
- Converts each unsigned element to decimal ASCII and streams the bytes over a valid/ready byte interface into the UART TX wrapper.
- Output format: elements separated by one space, each row terminated by CR LF.
- Sits between the top-level control FSM (which issues start/base/dims) and uart_tx.

---
 rtl/matrix_io_pkg.sv | 56 +++++
 rtl/dec_digit_conv.sv | 106 ++++++++++
 rtl/matrix_output_formatter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_matrix_output_formatter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_io_pkg.sv
// Shared constants, frame-formatter state encoding and small helpers for the
// matrix I/O path (ASCII codes, legal dimension range, decimal digit access).
package matrix_io_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam logic [2:0] DIM_MIN = 3'd1;
    localparam logic [2:0] DIM_MAX = 3'd5;

    typedef logic [3:0] fmt_state_t;

    localparam fmt_state_t ST_IDLE     = 4'd0;
    localparam fmt_state_t ST_CHECK    = 4'd1;
    localparam fmt_state_t ST_RD_ADDR  = 4'd2;
    localparam fmt_state_t ST_RD_WAIT  = 4'd3;
    localparam fmt_state_t ST_CONVERT  = 4'd4;
    localparam fmt_state_t ST_SEND_DIG = 4'd5;
    localparam fmt_state_t ST_SEND_SEP = 4'd6;
    localparam fmt_state_t ST_SEND_CR  = 4'd7;
    localparam fmt_state_t ST_SEND_LF  = 4'd8;
    localparam fmt_state_t ST_DONE     = 4'd9;

    function automatic logic dim_ok(input logic [2:0] d);
        return (d >= DIM_MIN) && (d <= DIM_MAX);
    endfunction

    // Decimal weight for digit position 0 (ten-thousands) .. 4 (units).
    function automatic logic [15:0] dec_weight(input logic [2:0] pos);
        logic [15:0] w;
        case (pos)
            3'd0:    w = 16'd10000;
            3'd1:    w = 16'd1000;
            3'd2:    w = 16'd100;
            3'd3:    w = 16'd10;
            default: w = 16'd1;
        endcase
        return w;
    endfunction

    // Digit idx 0 is the most significant and lives in digits[3:0].
    function automatic logic [7:0] bcd_ascii(input logic [19:0] digits, input logic [2:0] idx);
        logic [3:0] d;
        case (idx)
            3'd0:    d = digits[3:0];
            3'd1:    d = digits[7:4];
            3'd2:    d = digits[11:8];
            3'd3:    d = digits[15:12];
            default: d = digits[19:16];
        endcase
        return ASC_0 + {4'd0, d};
    endfunction

endpackage

// File: rtl/dec_digit_conv.sv
// Binary-to-decimal converter using repeated subtraction against 10000..1;
// yields 5 BCD digits (index 0 most significant) and the first significant index.
module dec_digit_conv
    import matrix_io_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              done,
    output logic [19:0]       digits,
    output logic [2:0]        lead_idx
);

    logic              run_q,   run_d;
    logic              done_q,  done_d;
    logic              found_q, found_d;
    logic [2:0]        pos_q,   pos_d;
    logic [2:0]        lead_q,  lead_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [19:0]       dig_q,   dig_d;
    logic [DATA_W-1:0] rem_q,   rem_d;
    logic [DATA_W-1:0] weight_s;

    // Subtraction sequencer: one subtraction or one digit store per cycle.
    always_comb begin
        run_d    = run_q;
        done_d   = 1'b0;
        found_d  = found_q;
        pos_d    = pos_q;
        lead_d   = lead_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        rem_d    = rem_q;
        weight_s = DATA_W'(dec_weight(pos_q));
        if (clr) begin
            run_d = 1'b0;
        end else if (!run_q) begin
            if (start) begin
                run_d   = 1'b1;
                rem_d   = value;
                pos_d   = 3'd0;
                cnt_d   = 4'd0;
                found_d = 1'b0;
                lead_d  = 3'd4;
            end else begin
                run_d = 1'b0;
            end
        end else if (rem_q >= weight_s) begin
            rem_d = rem_q - weight_s;
            cnt_d = cnt_q + 4'd1;
        end else begin
            case (pos_q)
                3'd0:    dig_d[3:0]   = cnt_q;
                3'd1:    dig_d[7:4]   = cnt_q;
                3'd2:    dig_d[11:8]  = cnt_q;
                3'd3:    dig_d[15:12] = cnt_q;
                default: dig_d[19:16] = cnt_q;
            endcase
            if ((cnt_q != 4'd0) && !found_q) begin
                found_d = 1'b1;
                lead_d  = pos_q;
            end else begin
                found_d = found_q;
            end
            cnt_d = 4'd0;
            if (pos_q == 3'd4) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                pos_d = pos_q + 3'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            pos_q   <= 3'd0;
            lead_q  <= 3'd0;
            cnt_q   <= 4'd0;
            dig_q   <= 20'd0;
            rem_q   <= '0;
        end else begin
            run_q   <= run_d;
            done_q  <= done_d;
            found_q <= found_d;
            pos_q   <= pos_d;
            lead_q  <= lead_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            rem_q   <= rem_d;
        end
    end

    assign done     = done_q;
    assign digits   = dig_q;
    assign lead_idx = lead_q;

endmodule

// File: rtl/matrix_output_formatter.sv
// Streams an m x n matrix from storage as decimal ASCII rows, space separated and
// CR LF terminated. Macro OUT_PAD_EN right-aligns each element in a PAD_W field.
module matrix_output_formatter
    import matrix_io_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int PAD_W  = 5
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en_output,
    input  logic              w_start,
    input  logic [ADDR_W-1:0] w_base_addr,
    input  logic [2:0]        w_dim_m,
    input  logic [2:0]        w_dim_n,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [DATA_W-1:0] w_rd_data,
    output logic [7:0]        w_tx_data,
    output logic              w_tx_valid,
    input  logic              w_tx_ready,
    output logic              w_busy,
    output logic              w_tx_done,
    output logic              w_dim_err
);

`ifdef OUT_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam logic [7:0] FIELD_W = PAD_EN ? 8'(PAD_W) : 8'd0;

    fmt_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]        m_q, m_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [2:0]        dig_idx_q, dig_idx_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        pad_left_q, pad_left_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dim_err_q, dim_err_d;
    logic              conv_go_q, conv_go_d;

    logic              conv_done_s;
    logic              conv_clr_s;
    logic [19:0]       conv_digits_s;
    logic [2:0]        conv_lead_s;
    logic [7:0]        ndig_s;
    logic [7:0]        pad_cnt_s;
    logic              xfer_s;

    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [2:0] row,
                                                    input logic [2:0] col,
                                                    input logic [2:0] n);
        return base + ADDR_W'(row) * ADDR_W'(n) + ADDR_W'(col);
    endfunction

    assign conv_clr_s = ~w_en_output;
    assign xfer_s     = tx_valid_q & w_tx_ready;

    dec_digit_conv #(
        .DATA_W (DATA_W)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .clr      (conv_clr_s),
        .start    (conv_go_q),
        .value    (value_q),
        .done     (conv_done_s),
        .digits   (conv_digits_s),
        .lead_idx (conv_lead_s)
    );

    // Leading-space count for the current element (zero when padding is off).
    always_comb begin
        ndig_s    = 8'd5 - {5'd0, conv_lead_s};
        pad_cnt_s = (FIELD_W > ndig_s) ? (FIELD_W - ndig_s) : 8'd0;
    end

    // Framing FSM; each send state presents its byte already registered.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rd_addr_d  = rd_addr_q;
        m_d        = m_q;
        n_d        = n_q;
        row_d      = row_q;
        col_d      = col_q;
        dig_idx_d  = dig_idx_q;
        value_d    = value_q;
        tx_data_d  = tx_data_q;
        pad_left_d = pad_left_q;
        tx_valid_d = tx_valid_q;
        dim_err_d  = dim_err_q;
        done_d     = 1'b0;
        conv_go_d  = 1'b0;
        if (!w_en_output) begin
            state_d    = ST_IDLE;
            row_d      = 3'd0;
            col_d      = 3'd0;
            dig_idx_d  = 3'd0;
            pad_left_d = 8'd0;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        base_d  = w_base_addr;
                        m_d     = w_dim_m;
                        n_d     = w_dim_n;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (dim_ok(m_q) && dim_ok(n_q)) begin
                        dim_err_d = 1'b0;
                        rd_addr_d = elem_addr(base_q, 3'd0, 3'd0, n_q);
                        state_d   = ST_RD_ADDR;
                    end else begin
                        dim_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    value_d   = w_rd_data;
                    conv_go_d = 1'b1;
                    state_d   = ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (conv_done_s) begin
                        pad_left_d = pad_cnt_s;
                        dig_idx_d  = conv_lead_s;
                        tx_valid_d = 1'b1;
                        tx_data_d  = (pad_cnt_s != 8'd0) ? ASC_SPACE
                                                         : bcd_ascii(conv_digits_s, conv_lead_s);
                        state_d    = ST_SEND_DIG;
                    end else begin
                        state_d = ST_CONVERT;
                    end
                end
                ST_SEND_DIG: begin
                    if (!xfer_s) begin
                        state_d = ST_SEND_DIG;
                    end else if (pad_left_q > 8'd1) begin
                        pad_left_d = pad_left_q - 8'd1;
                        tx_data_d  = ASC_SPACE;
                    end else if (pad_left_q == 8'd1) begin
                        pad_left_d = 8'd0;
                        tx_data_d  = bcd_ascii(conv_digits_s, dig_idx_q);
                    end else if (dig_idx_q < 3'd4) begin
                        dig_idx_d = dig_idx_q + 3'd1;
                        tx_data_d = bcd_ascii(conv_digits_s, dig_idx_q + 3'd1);
                    end else if (col_q < (n_q - 3'd1)) begin
                        col_d     = col_q + 3'd1;
                        tx_data_d = ASC_SPACE;
                        state_d   = ST_SEND_SEP;
                    end else begin
                        tx_data_d = ASC_CR;
                        state_d   = ST_SEND_CR;
                    end
                end
                ST_SEND_SEP: begin
                    if (xfer_s) begin
                        tx_valid_d = 1'b0;
                        rd_addr_d  = elem_addr(base_q, row_q, col_q, n_q);
                        state_d    = ST_RD_ADDR;
                    end else begin
                        state_d = ST_SEND_SEP;
                    end
                end
                ST_SEND_CR: begin
                    if (xfer_s) begin
                        tx_data_d = ASC_LF;
                        state_d   = ST_SEND_LF;
                    end else begin
                        state_d = ST_SEND_CR;
                    end
                end
                ST_SEND_LF: begin
                    if (!xfer_s) begin
                        state_d = ST_SEND_LF;
                    end else if (row_q < (m_q - 3'd1)) begin
                        tx_valid_d = 1'b0;
                        row_d      = row_q + 3'd1;
                        col_d      = 3'd0;
                        rd_addr_d  = elem_addr(base_q, row_q + 3'd1, 3'd0, n_q);
                        state_d    = ST_RD_ADDR;
                    end else begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            rd_addr_q  <= '0;
            m_q        <= 3'd0;
            n_q        <= 3'd0;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            dig_idx_q  <= 3'd0;
            value_q    <= '0;
            tx_data_q  <= 8'd0;
            pad_left_q <= 8'd0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dim_err_q  <= 1'b0;
            conv_go_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rd_addr_q  <= rd_addr_d;
            m_q        <= m_d;
            n_q        <= n_d;
            row_q      <= row_d;
            col_q      <= col_d;
            dig_idx_q  <= dig_idx_d;
            value_q    <= value_d;
            tx_data_q  <= tx_data_d;
            pad_left_q <= pad_left_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dim_err_q  <= dim_err_d;
            conv_go_q  <= conv_go_d;
        end
    end

    assign w_rd_addr  = rd_addr_q;
    assign w_tx_data  = tx_data_q;
    assign w_tx_valid = tx_valid_q;
    assign w_busy     = busy_q;
    assign w_tx_done  = done_q;
    assign w_dim_err  = dim_err_q;

endmodule

// File: tb/tb_matrix_output_formatter.sv
// Self-checking bench for matrix_output_formatter: directed vector table,
// abort/reset sequences and random frames against a string-level reference model.
module tb_matrix_output_formatter;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 8;
    localparam int PAD_W        = 5;
    localparam int NV           = 8;
    localparam int FRAME_BUDGET = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic              w_en_output;
    logic              w_start;
    logic [ADDR_W-1:0] w_base_addr;
    logic [2:0]        w_dim_m;
    logic [2:0]        w_dim_n;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [7:0]        w_tx_data;
    logic              w_tx_valid;
    logic              w_tx_ready;
    logic              w_busy;
    logic              w_tx_done;
    logic              w_dim_err;

    matrix_output_formatter #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PAD_W  (PAD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en_output (w_en_output),
        .w_start     (w_start),
        .w_base_addr (w_base_addr),
        .w_dim_m     (w_dim_m),
        .w_dim_n     (w_dim_n),
        .w_rd_addr   (w_rd_addr),
        .w_rd_data   (w_rd_data),
        .w_tx_data   (w_tx_data),
        .w_tx_valid  (w_tx_valid),
        .w_tx_ready  (w_tx_ready),
        .w_busy      (w_busy),
        .w_tx_done   (w_tx_done),
        .w_dim_err   (w_dim_err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) w_rd_data <= mem[w_rd_addr];

    typedef struct {
        logic [7:0]       base;
        logic [2:0]       m;
        logic [2:0]       n;
        int               mode;
        logic [5:0][15:0] vals;
        bit               exp_err;
    } vec_t;

    vec_t  vecs [NV];
    string exp_tab [NV];

    int         checks = 0;
    int         errors = 0;
    int         cyc_cnt = 0;
    int         done_cnt;
    int         stab_bad;
    bit         valid_seen;
    bit         have_hold;
    bit         busy2;
    bit         end_busy;
    logic [7:0] hold_data;
    logic [7:0] got_q [$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_stream(input string name, input string exp);
        int nbad;
        nbad = 0;
        check({name, "_len"}, got_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            if (i >= got_q.size()) begin
                nbad++;
            end else if (got_q[i] != exp.getc(i)) begin
                if (nbad == 0)
                    $display("  %s first diff at byte %0d: got %02h want %02h",
                             name, i, got_q[i], exp.getc(i));
                nbad++;
            end
        end
        check({name, "_bytes"}, nbad, 0);
    endtask

    // Reference model: plain decimal text, optional right alignment.
    function automatic string elem_str(input logic [15:0] v);
        string s;
        s = $sformatf("%0d", v);
`ifdef OUT_PAD_EN
        while (s.len() < PAD_W) s = {" ", s};
`endif
        return s;
    endfunction

    function automatic string frame_str(input logic [7:0] base, input int m, input int n);
        string s;
        s = "";
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                s = {s, elem_str(mem[8'(base + r * n + c)])};
                if (c < n - 1) s = {s, " "};
            end
            s = {s, "\015\012"};
        end
        return s;
    endfunction

    task automatic set_vec(input int i, input logic [7:0] base, input logic [2:0] m,
                           input logic [2:0] n, input int mode,
                           input int v0, input int v1, input int v2,
                           input int v3, input int v4, input int v5,
                           input bit err, input string exp);
        vecs[i].base    = base;
        vecs[i].m       = m;
        vecs[i].n       = n;
        vecs[i].mode    = mode;
        vecs[i].vals[0] = 16'(v0);
        vecs[i].vals[1] = 16'(v1);
        vecs[i].vals[2] = 16'(v2);
        vecs[i].vals[3] = 16'(v3);
        vecs[i].vals[4] = 16'(v4);
        vecs[i].vals[5] = 16'(v5);
        vecs[i].exp_err = err;
        exp_tab[i]      = exp;
    endtask

    // mode 0: ready always high, 1: high one cycle in four, 2: random.
    task automatic run_frame(input logic [7:0] base, input logic [2:0] m, input logic [2:0] n,
                             input int mode, input bit poke);
        int cycles;
        got_q.delete();
        done_cnt   = 0;
        stab_bad   = 0;
        valid_seen = 1'b0;
        have_hold  = 1'b0;
        busy2      = 1'b1;
        @(negedge clk);
        w_base_addr = base;
        w_dim_m     = m;
        w_dim_n     = n;
        w_start     = 1'b1;
        cycles      = 0;
        while (cycles < FRAME_BUDGET) begin
            @(negedge clk);
            cycles++;
            cyc_cnt++;
            w_start = 1'b0;
            if (poke && cycles == 5) begin
                w_dim_m = 3'd6;
                w_start = 1'b1;
            end
            if (have_hold && (!w_tx_valid || w_tx_data != hold_data)) stab_bad++;
            case (mode)
                0:       w_tx_ready = 1'b1;
                1:       w_tx_ready = ((cyc_cnt % 4) == 0);
                default: w_tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (w_tx_valid) valid_seen = 1'b1;
            if (w_tx_valid && w_tx_ready) got_q.push_back(w_tx_data);
            have_hold = w_tx_valid && !w_tx_ready;
            hold_data = w_tx_data;
            if (w_tx_done) done_cnt++;
            if (cycles == 2) busy2 = w_busy;
            if (!w_busy && cycles > 2) break;
        end
        end_busy   = w_busy;
        w_start    = 1'b0;
        w_tx_ready = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_addr"}, int'(w_rd_addr), 0);
        check({tag, "_tx_data"}, int'(w_tx_data), 0);
        check({tag, "_tx_valid"}, int'(w_tx_valid), 0);
        check({tag, "_busy"}, int'(w_busy), 0);
        check({tag, "_tx_done"}, int'(w_tx_done), 0);
        check({tag, "_dim_err"}, int'(w_dim_err), 0);
    endtask

    initial begin
        int    nbytes;
        int    cnt;
        int    m;
        int    n;
        string exp;
        logic [7:0] base;

        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
        rst         = 1'b1;
        w_en_output = 1'b1;
        w_start     = 1'b0;
        w_base_addr = 8'd0;
        w_dim_m     = 3'd0;
        w_dim_n     = 3'd0;
        w_tx_ready  = 1'b1;

`ifdef OUT_PAD_EN
        set_vec(0, 8'd0,   3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0, 1'b0, "    0\015\012");
        set_vec(1, 8'd10,  3'd2, 3'd3, 0, 1, 23, 456, 7, 0, 65535, 1'b0,
                "    1    23   456\015\012    7     0 65535\015\012");
        set_vec(2, 8'd10,  3'd2, 3'd3, 1, 1, 23, 456, 7, 0, 65535, 1'b0,
                "    1    23   456\015\012    7     0 65535\015\012");
        set_vec(3, 8'd254, 3'd1, 3'd3, 2, 7, 12, 9999, 0, 0, 0, 1'b0, "    7    12  9999\015\012");
        set_vec(5, 8'd3,   3'd1, 3'd1, 0, 42, 0, 0, 0, 0, 0, 1'b0, "   42\015\012");
`else
        set_vec(0, 8'd0,   3'd1, 3'd1, 0, 0, 0, 0, 0, 0, 0, 1'b0, "0\015\012");
        set_vec(1, 8'd10,  3'd2, 3'd3, 0, 1, 23, 456, 7, 0, 65535, 1'b0,
                "1 23 456\015\0127 0 65535\015\012");
        set_vec(2, 8'd10,  3'd2, 3'd3, 1, 1, 23, 456, 7, 0, 65535, 1'b0,
                "1 23 456\015\0127 0 65535\015\012");
        set_vec(3, 8'd254, 3'd1, 3'd3, 2, 7, 12, 9999, 0, 0, 0, 1'b0, "7 12 9999\015\012");
        set_vec(5, 8'd3,   3'd1, 3'd1, 0, 42, 0, 0, 0, 0, 0, 1'b0, "42\015\012");
`endif
        set_vec(4, 8'd20, 3'd6, 3'd2, 0, 0, 0, 0, 0, 0, 0, 1'b1, "");
        set_vec(6, 8'd20, 3'd0, 3'd3, 0, 0, 0, 0, 0, 0, 0, 1'b1, "");
        set_vec(7, 8'd20, 3'd2, 3'd7, 2, 0, 0, 0, 0, 0, 0, 1'b1, "");

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (!vecs[i].exp_err) begin
                for (int k = 0; k < int'(vecs[i].m) * int'(vecs[i].n); k++)
                    mem[8'(vecs[i].base + k)] = vecs[i].vals[k];
            end
            run_frame(vecs[i].base, vecs[i].m, vecs[i].n, vecs[i].mode, 1'b0);
            check_stream($sformatf("v%0d_stream", i), exp_tab[i]);
            check($sformatf("v%0d_dim_err", i), int'(w_dim_err), int'(vecs[i].exp_err));
            check($sformatf("v%0d_done_pulses", i), done_cnt, vecs[i].exp_err ? 0 : 1);
            check($sformatf("v%0d_hold_stable", i), stab_bad, 0);
            check($sformatf("v%0d_timeout", i), int'(end_busy), 0);
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d_busy_at2", i), int'(busy2), 0);
                check($sformatf("v%0d_valid_seen", i), int'(valid_seen), 0);
            end
        end

        // Enable dropped after three bytes of a 2x2 frame.
        mem[40] = 16'd5; mem[41] = 16'd6; mem[42] = 16'd7; mem[43] = 16'd8;
        @(negedge clk);
        w_base_addr = 8'd40; w_dim_m = 3'd2; w_dim_n = 3'd2; w_start = 1'b1;
        w_tx_ready  = 1'b1;
        nbytes = 0; cnt = 0; done_cnt = 0;
        while (nbytes < 3 && cnt < FRAME_BUDGET) begin
            @(negedge clk);
            w_start = 1'b0;
            cnt++;
            if (w_tx_valid && w_tx_ready) nbytes++;
            if (w_tx_done) done_cnt++;
        end
        check("en_drop_three_bytes", nbytes, 3);
        @(negedge clk);
        w_tx_ready  = 1'b0;
        w_en_output = 1'b0;
        @(negedge clk);
        check("en_drop_valid", int'(w_tx_valid), 0);
        check("en_drop_busy", int'(w_busy), 0);
        repeat (5) begin
            @(negedge clk);
            if (w_tx_done) done_cnt++;
        end
        check("en_drop_no_done", done_cnt, 0);
        w_en_output = 1'b1;
        w_tx_ready  = 1'b1;
        run_frame(8'd40, 3'd2, 3'd2, 0, 1'b0);
        check_stream("en_restart_stream", frame_str(8'd40, 2, 2));
        check("en_restart_done", done_cnt, 1);

        // Reset in the middle of a frame.
        @(negedge clk);
        w_base_addr = 8'd10; w_dim_m = 3'd2; w_dim_n = 3'd3; w_start = 1'b1;
        repeat (12) begin
            @(negedge clk);
            w_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("mid_rst");
        repeat (4) @(negedge clk);
        check("mid_rst_stays_idle", int'(w_busy), 0);

        // Random frames, random ready, occasional start pulse while busy.
        for (int t = 0; t < 20; t++) begin
            m    = $urandom_range(1, 5);
            n    = $urandom_range(1, 5);
            base = 8'($urandom_range(0, 255));
            for (int k = 0; k < m * n; k++) begin
                case ($urandom_range(0, 3))
                    0:       mem[8'(base + k)] = 16'd0;
                    1:       mem[8'(base + k)] = 16'($urandom_range(0, 9));
                    2:       mem[8'(base + k)] = 16'($urandom_range(0, 999));
                    default: mem[8'(base + k)] = 16'($urandom_range(0, 65535));
                endcase
            end
            exp = frame_str(base, m, n);
            run_frame(base, 3'(m), 3'(n), 2, 1'($urandom_range(0, 1)));
            check_stream($sformatf("rnd%0d_stream", t), exp);
            check($sformatf("rnd%0d_done_pulses", t), done_cnt, 1);
            check($sformatf("rnd%0d_hold_stable", t), stab_bad, 0);
            check($sformatf("rnd%0d_dim_err", t), int'(w_dim_err), 0);
            check($sformatf("rnd%0d_timeout", t), int'(end_busy), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
